// File: rtl/io_mmio_ctrl.sv
// MMIO register block for the I/O region: UART status/rx/tx registers with
// ready/valid handshakes, plus software-resettable cycle and retired-instruction counters.
module io_mmio_ctrl #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              io_en,
    input  logic              io_store_en,
    input  logic [3:0]        io_wea,
    input  logic [ADDR_W-1:0] io_addr,
    input  logic [31:0]       io_wdata,
    output logic [31:0]       io_rdata,
    input  logic              inst_retire,
    output logic [7:0]        uart_tx_data,
    output logic              uart_tx_valid,
    input  logic              uart_tx_ready,
    input  logic [7:0]        uart_rx_data,
    input  logic              uart_rx_valid,
    output logic              uart_rx_ready
);

    // Word indices within the I/O window (io_addr[7:2]).
    localparam int IDX_UART_CTRL = 0;
    localparam int IDX_UART_RX   = 1;
    localparam int IDX_UART_TX   = 2;
    localparam int IDX_CYCLE     = 4;
    localparam int IDX_INST      = 5;
    localparam int IDX_CNT_RST   = 6;
    localparam int NUM_REGS      = 7;

    logic                wr;
    logic                rd;
    logic [5:0]          reg_idx;
    logic [NUM_REGS-1:0] reg_hit;

    logic [31:0]         io_rdata_reg;
    logic [31:0]         rdata_next;
    logic [7:0]          uart_tx_data_reg;
    logic                uart_tx_valid_reg;
    logic                tx_load;
    logic                tx_done;

    logic [CNT_W-1:0]    cycle_cnt_reg;
    logic [CNT_W-1:0]    inst_cnt_reg;
    logic                cnt_clear;
    logic [31:0]         cycle_rd;
    logic [31:0]         inst_rd;

    assign wr      = io_en & io_store_en & (|io_wea);
    assign rd      = io_en & (io_wea == 4'b0000);
    assign reg_idx = io_addr[7:2];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_decode
            assign reg_hit[gi] = (reg_idx == 6'(gi));
        end
    endgenerate

    // Counters are presented as 32-bit words regardless of CNT_W.
    generate
        if (CNT_W == 32) begin : g_cnt_exact
            assign cycle_rd = cycle_cnt_reg;
            assign inst_rd  = inst_cnt_reg;
        end else if (CNT_W < 32) begin : g_cnt_narrow
            assign cycle_rd = {{(32-CNT_W){1'b0}}, cycle_cnt_reg};
            assign inst_rd  = {{(32-CNT_W){1'b0}}, inst_cnt_reg};
        end else begin : g_cnt_wide
            logic unused_cnt_hi;
            assign cycle_rd      = cycle_cnt_reg[31:0];
            assign inst_rd       = inst_cnt_reg[31:0];
            assign unused_cnt_hi = ^{cycle_cnt_reg[CNT_W-1:32], inst_cnt_reg[CNT_W-1:32]};
        end
    endgenerate

    // Handshake happens in the load cycle itself; rdata captures the byte at the same edge.
    assign uart_rx_ready = ~rst & rd & reg_hit[IDX_UART_RX] & uart_rx_valid;

    always_comb begin
        rdata_next = '0;
        if (reg_hit[IDX_UART_CTRL]) rdata_next = {30'b0, uart_rx_valid, ~uart_tx_valid_reg};
        if (reg_hit[IDX_UART_RX])   rdata_next = {24'b0, uart_rx_data};
        if (reg_hit[IDX_CYCLE])     rdata_next = cycle_rd;
        if (reg_hit[IDX_INST])      rdata_next = inst_rd;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            io_rdata_reg <= '0;
        end else if (io_en) begin
            io_rdata_reg <= rdata_next;
        end
    end

    // A store to the tx register while a byte is pending is dropped.
    assign tx_load = wr & reg_hit[IDX_UART_TX] & io_wea[0] & ~uart_tx_valid_reg;
    assign tx_done = uart_tx_valid_reg & uart_tx_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            uart_tx_valid_reg <= 1'b0;
            uart_tx_data_reg  <= '0;
        end else if (tx_done) begin
            uart_tx_valid_reg <= 1'b0;
        end else if (tx_load) begin
            uart_tx_valid_reg <= 1'b1;
            uart_tx_data_reg  <= io_wdata[7:0];
        end
    end

    assign cnt_clear = wr & reg_hit[IDX_CNT_RST];

    always_ff @(posedge clk) begin
        if (rst || cnt_clear) begin
            cycle_cnt_reg <= '0;
            inst_cnt_reg  <= '0;
        end else begin
            cycle_cnt_reg <= cycle_cnt_reg + CNT_W'(1);
            if (inst_retire) begin
                inst_cnt_reg <= inst_cnt_reg + CNT_W'(1);
            end
        end
    end

    assign io_rdata      = io_rdata_reg;
    assign uart_tx_data  = uart_tx_data_reg;
    assign uart_tx_valid = uart_tx_valid_reg;

    logic unused_ok;
    assign unused_ok = ^{io_addr[ADDR_W-1:8], io_addr[1:0], io_wdata[31:8], reg_hit[3]};

endmodule

// File: tb/tb_io_mmio_ctrl.sv
// Self-checking bench for io_mmio_ctrl: read expectations go through a scoreboard
// queue at issue time and are compared when io_rdata becomes valid one cycle later.
`timescale 1ns/1ps
module tb_io_mmio_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        io_en = 1'b0;
    logic        io_store_en = 1'b0;
    logic [3:0]  io_wea = 4'b0;
    logic [31:0] io_addr = 32'b0;
    logic [31:0] io_wdata = 32'b0;
    logic [31:0] io_rdata;
    logic        inst_retire = 1'b0;
    logic [7:0]  uart_tx_data;
    logic        uart_tx_valid;
    logic        uart_tx_ready = 1'b0;
    logic [7:0]  uart_rx_data = 8'b0;
    logic        uart_rx_valid = 1'b0;
    logic        uart_rx_ready;

    int          tests_run = 0;
    int          tests_failed = 0;
    logic [31:0] exp_q[$];
    int          tx_xfer_cnt = 0;
    logic [7:0]  tx_last_byte = 8'h00;
    int          rx_xfer_cnt = 0;

    io_mmio_ctrl #(.ADDR_W(32), .CNT_W(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .io_en         (io_en),
        .io_store_en   (io_store_en),
        .io_wea        (io_wea),
        .io_addr       (io_addr),
        .io_wdata      (io_wdata),
        .io_rdata      (io_rdata),
        .inst_retire   (inst_retire),
        .uart_tx_data  (uart_tx_data),
        .uart_tx_valid (uart_tx_valid),
        .uart_tx_ready (uart_tx_ready),
        .uart_rx_data  (uart_rx_data),
        .uart_rx_valid (uart_rx_valid),
        .uart_rx_ready (uart_rx_ready)
    );

    always #5 clk = ~clk;

    // Count handshakes as the UART side would see them.
    always @(posedge clk) begin
        if (uart_tx_valid === 1'b1 && uart_tx_ready === 1'b1) begin
            tx_xfer_cnt++;
            tx_last_byte = uart_tx_data;
        end
        if (uart_rx_valid === 1'b1 && uart_rx_ready === 1'b1) begin
            rx_xfer_cnt++;
        end
    end

    task automatic drive_read(input logic [7:0] off);
        io_en = 1'b1; io_store_en = 1'b0; io_wea = 4'b0000;
        io_addr = {24'b0, off}; io_wdata = 32'b0;
    endtask

    task automatic drive_write(input logic [7:0] off, input logic [31:0] data, input logic [3:0] wea);
        io_en = 1'b1; io_store_en = 1'b1; io_wea = wea;
        io_addr = {24'b0, off}; io_wdata = data;
    endtask

    task automatic drive_idle();
        io_en = 1'b0; io_store_en = 1'b0; io_wea = 4'b0000;
    endtask

    task automatic test_reset();
        logic [7:0]  offs [3];
        logic [31:0] vals [3];
        logic [31:0] exp;
        offs = '{8'h00, 8'h10, 8'h14};
        vals = '{32'h1, 32'h1, 32'h0};
        rst = 1'b1; uart_rx_valid = 1'b1; uart_rx_data = 8'hC3;
        drive_read(8'h04);
        repeat (3) begin
            @(negedge clk);
            tests_run++;
            if (uart_rx_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset_rx_ready: uart_rx_ready=%b expected 0", uart_rx_ready);
            end
        end
        rst = 1'b0; uart_rx_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_read(offs[i]);
            exp_q.push_back(vals[i]);
            @(negedge clk);
            exp = exp_q.pop_front();
            tests_run++;
            if (io_rdata !== exp) begin
                tests_failed++;
                $display("FAIL reset_read_%02h: io_rdata=%h expected %h", offs[i], io_rdata, exp);
            end
            $display("[TB] reset read 0x%02h -> %h", offs[i], io_rdata);
        end
        drive_idle();
    endtask

    task automatic test_tx();
        logic [31:0] exp;
        int          xfer_base;
        xfer_base = tx_xfer_cnt;
        uart_tx_ready = 1'b0;
        drive_write(8'h08, 32'h0000_0041, 4'b0001);
        @(negedge clk);
        tests_run++;
        if (uart_tx_valid !== 1'b1 || uart_tx_data !== 8'h41) begin
            tests_failed++;
            $display("FAIL tx_load: valid=%b data=%h expected valid=1 data=41", uart_tx_valid, uart_tx_data);
        end
        drive_write(8'h08, 32'h0000_0042, 4'b0001);
        @(negedge clk);
        tests_run++;
        if (uart_tx_valid !== 1'b1 || uart_tx_data !== 8'h41) begin
            tests_failed++;
            $display("FAIL tx_drop: valid=%b data=%h expected valid=1 data=41", uart_tx_valid, uart_tx_data);
        end
        drive_read(8'h00);
        exp_q.push_back(32'h0);
        @(negedge clk);
        exp = exp_q.pop_front();
        tests_run++;
        if (io_rdata !== exp) begin
            tests_failed++;
            $display("FAIL tx_busy_status: io_rdata=%h expected %h", io_rdata, exp);
        end
        drive_idle();
        uart_tx_ready = 1'b1;
        @(negedge clk);
        uart_tx_ready = 1'b0;
        tests_run++;
        if (uart_tx_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL tx_release: valid=%b expected 0", uart_tx_valid);
        end
        drive_read(8'h00);
        exp_q.push_back(32'h1);
        @(negedge clk);
        exp = exp_q.pop_front();
        tests_run++;
        if (io_rdata !== exp) begin
            tests_failed++;
            $display("FAIL tx_idle_status: io_rdata=%h expected %h", io_rdata, exp);
        end
        drive_idle();
        tests_run++;
        if (tx_xfer_cnt !== xfer_base + 1 || tx_last_byte !== 8'h41) begin
            tests_failed++;
            $display("FAIL tx_transfer: count=%0d byte=%h expected count=%0d byte=41",
                     tx_xfer_cnt - xfer_base, tx_last_byte, 1);
        end
        $display("[TB] tx byte 0x41 transferred %0d time(s)", tx_xfer_cnt - xfer_base);
        // Reset while a byte is pending must discard it.
        drive_write(8'h08, 32'h0000_0099, 4'b0001);
        @(negedge clk);
        drive_idle();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tests_run++;
        if (uart_tx_valid !== 1'b0 || uart_tx_data !== 8'h00) begin
            tests_failed++;
            $display("FAIL tx_reset_discard: valid=%b data=%h expected valid=0 data=00", uart_tx_valid, uart_tx_data);
        end
    endtask

    task automatic test_rx();
        logic [31:0] exp;
        int          rx_base;
        // Hold a tx byte pending so the status word isolates the rx bit.
        uart_tx_ready = 1'b0;
        drive_write(8'h08, 32'h0000_0033, 4'b0001);
        @(negedge clk);
        rx_base = rx_xfer_cnt;
        uart_rx_valid = 1'b1; uart_rx_data = 8'h5A;
        drive_read(8'h00);
        exp_q.push_back(32'h2);
        #1;
        tests_run++;
        if (uart_rx_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL rx_ready_on_status: uart_rx_ready=%b expected 0", uart_rx_ready);
        end
        @(negedge clk);
        exp = exp_q.pop_front();
        tests_run++;
        if (io_rdata !== exp) begin
            tests_failed++;
            $display("FAIL rx_status: io_rdata=%h expected %h", io_rdata, exp);
        end
        drive_read(8'h04);
        exp_q.push_back(32'h0000_005A);
        #1;
        tests_run++;
        if (uart_rx_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL rx_ready_pulse: uart_rx_ready=%b expected 1", uart_rx_ready);
        end
        @(negedge clk);
        exp = exp_q.pop_front();
        tests_run++;
        if (io_rdata !== exp) begin
            tests_failed++;
            $display("FAIL rx_data: io_rdata=%h expected %h", io_rdata, exp);
        end
        uart_rx_valid = 1'b0;
        drive_read(8'h04);
        exp_q.push_back(32'h0000_005A);
        #1;
        tests_run++;
        if (uart_rx_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL rx_no_valid_ready: uart_rx_ready=%b expected 0", uart_rx_ready);
        end
        @(negedge clk);
        exp = exp_q.pop_front();
        tests_run++;
        if (io_rdata !== exp) begin
            tests_failed++;
            $display("FAIL rx_data_no_valid: io_rdata=%h expected %h", io_rdata, exp);
        end
        drive_idle();
        tests_run++;
        if (rx_xfer_cnt !== rx_base + 1) begin
            tests_failed++;
            $display("FAIL rx_transfer_count: count=%0d expected 1", rx_xfer_cnt - rx_base);
        end
        $display("[TB] rx byte 0x5A consumed, handshakes=%0d", rx_xfer_cnt - rx_base);
        uart_tx_ready = 1'b1;
        @(negedge clk);
        uart_tx_ready = 1'b0;
    endtask

    task automatic test_counters();
        logic [31:0] exp;
        logic [9:0]  pattern;
        logic [7:0]  offs [6];
        logic [31:0] vals [6];
        pattern = 10'b10_1101_1101;
        offs = '{8'h14, 8'h10, 8'h14, 8'h10, 8'h14, 8'h10};
        vals = '{32'd0, 32'd1, 32'd7, 32'd13, 32'd0, 32'd1};
        drive_write(8'h18, 32'h0, 4'hF);
        inst_retire = 1'b1;
        @(negedge clk);
        inst_retire = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i == 2) begin
                drive_idle();
                for (int k = 0; k < 10; k++) begin
                    inst_retire = pattern[k];
                    @(negedge clk);
                end
                inst_retire = 1'b0;
            end
            if (i == 4) begin
                // Clear must win over a same-cycle retire pulse.
                drive_write(8'h18, 32'h0, 4'hF);
                inst_retire = 1'b1;
                @(negedge clk);
                inst_retire = 1'b0;
            end
            drive_read(offs[i]);
            exp_q.push_back(vals[i]);
            @(negedge clk);
            exp = exp_q.pop_front();
            tests_run++;
            if (io_rdata !== exp) begin
                tests_failed++;
                $display("FAIL counter_read_%0d_%02h: io_rdata=%0d expected %0d", i, offs[i], io_rdata, exp);
            end
            $display("[TB] counter read 0x%02h -> %0d", offs[i], io_rdata);
        end
        drive_idle();
    endtask

    task automatic test_wrap();
        logic [31:0] exp;
        force dut.cycle_cnt_reg = 32'hFFFF_FFFF;
        #1;
        release dut.cycle_cnt_reg;
        drive_read(8'h10);
        exp_q.push_back(32'hFFFF_FFFF);
        @(negedge clk);
        exp = exp_q.pop_front();
        tests_run++;
        if (io_rdata !== exp) begin
            tests_failed++;
            $display("FAIL wrap_preload: io_rdata=%h expected %h", io_rdata, exp);
        end
        drive_read(8'h10);
        exp_q.push_back(32'h0);
        @(negedge clk);
        exp = exp_q.pop_front();
        tests_run++;
        if (io_rdata !== exp) begin
            tests_failed++;
            $display("FAIL wrap_zero: io_rdata=%h expected %h", io_rdata, exp);
        end
        $display("[TB] cycle counter wrapped to %h", io_rdata);
        drive_idle();
    endtask

    task automatic test_decode();
        logic [31:0] exp;
        drive_write(8'h18, 32'h0, 4'hF);
        @(negedge clk);
        drive_read(8'h00);
        exp_q.push_back(32'h1);
        @(negedge clk);
        exp = exp_q.pop_front();
        tests_run++;
        if (io_rdata !== exp) begin
            tests_failed++;
            $display("FAIL decode_status: io_rdata=%h expected %h", io_rdata, exp);
        end
        drive_idle();
        io_addr = 32'h0000_0010;
        exp_q.push_back(32'h1);
        @(negedge clk);
        exp = exp_q.pop_front();
        tests_run++;
        if (io_rdata !== exp) begin
            tests_failed++;
            $display("FAIL decode_io_en_hold: io_rdata=%h expected %h", io_rdata, exp);
        end
        drive_read(8'h1C);
        exp_q.push_back(32'h0);
        @(negedge clk);
        exp = exp_q.pop_front();
        tests_run++;
        if (io_rdata !== exp) begin
            tests_failed++;
            $display("FAIL decode_unmapped: io_rdata=%h expected %h", io_rdata, exp);
        end
        drive_write(8'h10, 32'h0, 4'hF);
        @(negedge clk);
        drive_read(8'h10);
        exp_q.push_back(32'd4);
        @(negedge clk);
        exp = exp_q.pop_front();
        tests_run++;
        if (io_rdata !== exp) begin
            tests_failed++;
            $display("FAIL decode_ro_cycle: io_rdata=%0d expected %0d", io_rdata, exp);
        end
        drive_write(8'h08, 32'h0000_0077, 4'b0010);
        @(negedge clk);
        tests_run++;
        if (uart_tx_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL decode_tx_wea: uart_tx_valid=%b expected 0", uart_tx_valid);
        end
        drive_read(8'h00);
        exp_q.push_back(32'h1);
        @(negedge clk);
        exp = exp_q.pop_front();
        tests_run++;
        if (io_rdata !== exp) begin
            tests_failed++;
            $display("FAIL decode_tx_wea_status: io_rdata=%h expected %h", io_rdata, exp);
        end
        $display("[TB] decode boundaries done, status=%h", io_rdata);
        drive_idle();
    endtask

    initial begin
        test_reset();
        test_tx();
        test_rx();
        test_counters();
        test_wrap();
        test_decode();
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
